// File: rtl/hazard_sequencer_if.sv
// Decode-stage hazard interface between the LEGv8 control path and the stall/flush sequencer.
// master = pipeline side supplying ID/EX status, slave = sequencer driving enables.
interface hazard_sequencer_if;
   logic [31:0] id_instr;
   logic        ex_is_load;
   logic [4:0]  ex_rd;
   logic        br_taken;
   logic        pc_write;
   logic        ifid_write;
   logic        idex_bubble;
   logic        ifid_flush;
   logic        mul_start;
   logic        mul_busy;
   logic [1:0]  state;

   modport master (
      output id_instr, ex_is_load, ex_rd, br_taken,
      input  pc_write, ifid_write, idex_bubble, ifid_flush, mul_start, mul_busy, state
   );

   modport slave (
      input  id_instr, ex_is_load, ex_rd, br_taken,
      output pc_write, ifid_write, idex_bubble, ifid_flush, mul_start, mul_busy, state
   );
endinterface

// File: rtl/hazard_sequencer.sv
// Stall/flush sequencer for the 5-stage LEGv8 pipeline: load-use stalls, MUL occupancy, branch flush.
// Optional macro HAZ_PERF_CNT_EN adds a saturating stall-cycle counter output stall_cnt.
module hazard_sequencer #(
   parameter int MUL_LAT   = 4,
   parameter int FLUSH_CYC = 1
) (
   input  logic              clk,
   input  logic              reset,
   hazard_sequencer_if.slave hz
`ifdef HAZ_PERF_CNT_EN
   ,
   output logic [15:0]       stall_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'b00,
      ST_MUL   = 2'b01,
      ST_FLUSH = 2'b10,
      ST_BAD   = 2'b11
   } state_t;

   localparam logic [3:0] MUL_RELOAD   = 4'((MUL_LAT > 1) ? (MUL_LAT - 2) : 0);
   localparam logic [3:0] FLUSH_RELOAD = 4'((FLUSH_CYC > 1) ? (FLUSH_CYC - 2) : 0);

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;

   logic [10:0] op11;
   logic [4:0]  rn, rm, rt;
   logic        is_mul, is_b, is_blt, uses_rn, uses_rm, uses_rt, lu;
   logic        pc_write, ifid_write, idex_bubble, ifid_flush, mul_start, mul_busy;

   always_comb begin
      op11    = hz.id_instr[31:21];
      rn      = hz.id_instr[9:5];
      rm      = hz.id_instr[20:16];
      rt      = hz.id_instr[4:0];
      is_mul  = (op11 == 11'b10011011000) && (hz.id_instr[15:10] == 6'b011111);
      is_b    = (hz.id_instr[31:26] == 6'b000101);
      is_blt  = (hz.id_instr[31:24] == 8'b01010100) && (rt == 5'b01011);
      uses_rn = !(is_b || is_blt);
      uses_rm = (op11 == 11'b10101011000) || (op11 == 11'b11101011000) || is_mul;
      uses_rt = (op11 == 11'b11111000000) || (hz.id_instr[31:24] == 8'b10110100);
      // X31 is XZR and never carries a real dependency.
      lu      = hz.ex_is_load && (hz.ex_rd != 5'd31) &&
                ((uses_rn && (hz.ex_rd == rn)) ||
                 (uses_rm && (hz.ex_rd == rm)) ||
                 (uses_rt && (hz.ex_rd == rt)));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_RUN;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d     = ST_RUN;
      cnt_d       = cnt_q;
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      idex_bubble = 1'b0;
      ifid_flush  = 1'b0;
      mul_start   = 1'b0;
      mul_busy    = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (lu) begin
               pc_write    = 1'b0;
               ifid_write  = 1'b0;
               idex_bubble = 1'b1;
            end else if (is_mul) begin
               mul_start = 1'b1;
               if (MUL_LAT > 1) begin
                  state_d = ST_MUL;
                  cnt_d   = MUL_RELOAD;
               end
            end else if (hz.br_taken) begin
               ifid_flush = 1'b1;
               if (FLUSH_CYC > 1) begin
                  state_d = ST_FLUSH;
                  cnt_d   = FLUSH_RELOAD;
               end
            end
         end
         ST_MUL: begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            mul_busy    = 1'b1;
            if (cnt_q != 4'd0) begin
               state_d = ST_MUL;
               cnt_d   = cnt_q - 4'd1;
            end
         end
         ST_FLUSH: begin
            ifid_flush = 1'b1;
            if (cnt_q != 4'd0) begin
               state_d = ST_FLUSH;
               cnt_d   = cnt_q - 4'd1;
            end
         end
         default: state_d = ST_RUN;
      endcase
      // Reset overrides everything so ID/EX and IF/ID are held at NOP.
      if (reset) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_bubble = 1'b1;
         ifid_flush  = 1'b1;
         mul_start   = 1'b0;
         mul_busy    = 1'b0;
      end
   end

   assign hz.pc_write    = pc_write;
   assign hz.ifid_write  = ifid_write;
   assign hz.idex_bubble = idex_bubble;
   assign hz.ifid_flush  = ifid_flush;
   assign hz.mul_start   = mul_start;
   assign hz.mul_busy    = mul_busy;
   assign hz.state       = reset ? 2'b00 : state_q;

`ifdef HAZ_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt <= 16'd0;
      end else if (!pc_write && (stall_cnt != 16'hFFFF)) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Bench for hazard_sequencer: directed scenarios against fixed output patterns, then random traffic against a cycle-count model.
module tb_hazard_sequencer;
   localparam int MUL_LAT   = 4;
   localparam int FLUSH_CYC = 2;

   // {state[1:0], pc_write, ifid_write, idex_bubble, ifid_flush, mul_start, mul_busy}
   localparam logic [7:0] P_RESET  = 8'b00_001100;
   localparam logic [7:0] P_DEF    = 8'b00_110000;
   localparam logic [7:0] P_STALL  = 8'b00_001000;
   localparam logic [7:0] P_MSTART = 8'b00_110010;
   localparam logic [7:0] P_MBUSY  = 8'b01_001001;
   localparam logic [7:0] P_FLUSH0 = 8'b00_110100;
   localparam logic [7:0] P_FLUSH1 = 8'b10_110100;

   localparam logic [31:0] I_ADDS = 32'hAB020024;
   localparam logic [31:0] I_MUL  = 32'h9B027C23;
   localparam logic [31:0] I_NOP  = 32'hD503201F;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   hazard_sequencer_if hz ();
`ifdef HAZ_PERF_CNT_EN
   logic [15:0] stall_cnt;
   logic [15:0] exp_stall = 16'd0;
`endif

   hazard_sequencer #(.MUL_LAT(MUL_LAT), .FLUSH_CYC(FLUSH_CYC)) dut (
      .clk   (clk),
      .reset (reset),
      .hz    (hz)
`ifdef HAZ_PERF_CNT_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] obs, exp_v;
   assign obs = {hz.state, hz.pc_write, hz.ifid_write, hz.idex_bubble,
                 hz.ifid_flush, hz.mul_start, hz.mul_busy};

   // Model: remaining busy/flush cycles counted directly from the latency parameters.
   int mul_rem = 0;
   int flush_rem = 0;
   logic m_lu, m_mul;

   function automatic logic model_is_mul(input logic [31:0] ins);
      return (ins[31:21] == 11'b10011011000) && (ins[15:10] == 6'b011111);
   endfunction

   function automatic logic model_lu(input logic [31:0] ins, input logic ld, input logic [4:0] rd);
      logic [4:0] srcs[$];
      if (!ld || rd == 5'd31) return 1'b0;
      if (ins[31:26] == 6'b000101) return 1'b0;
      if (ins[31:24] == 8'h54 && ins[4:0] == 5'b01011) return 1'b0;
      srcs.push_back(ins[9:5]);
      if (ins[31:21] == 11'b10101011000 || ins[31:21] == 11'b11101011000 || model_is_mul(ins))
         srcs.push_back(ins[20:16]);
      if (ins[31:21] == 11'b11111000000 || ins[31:24] == 8'b10110100)
         srcs.push_back(ins[4:0]);
      foreach (srcs[i]) if (srcs[i] == rd) return 1'b1;
      return 1'b0;
   endfunction

   assign m_lu  = model_lu(hz.id_instr, hz.ex_is_load, hz.ex_rd);
   assign m_mul = model_is_mul(hz.id_instr);

   always_comb begin
      exp_v = P_DEF;
      if (reset)              exp_v = P_RESET;
      else if (mul_rem > 0)   exp_v = P_MBUSY;
      else if (flush_rem > 0) exp_v = P_FLUSH1;
      else if (m_lu)          exp_v = P_STALL;
      else if (m_mul)         exp_v = P_MSTART;
      else if (hz.br_taken)   exp_v = P_FLUSH0;
   end

   always @(posedge clk) begin
      if (reset) begin
         mul_rem   <= 0;
         flush_rem <= 0;
`ifdef HAZ_PERF_CNT_EN
         exp_stall <= 16'd0;
`endif
      end else begin
`ifdef HAZ_PERF_CNT_EN
         if (!exp_v[5] && exp_stall != 16'hFFFF) exp_stall <= exp_stall + 16'd1;
`endif
         if (mul_rem > 0)                    mul_rem   <= mul_rem - 1;
         else if (flush_rem > 0)             flush_rem <= flush_rem - 1;
         else if (!m_lu && m_mul)            mul_rem   <= MUL_LAT - 1;
         else if (!m_lu && hz.br_taken)      flush_rem <= FLUSH_CYC - 1;
      end
   end

   task automatic apply(input logic [31:0] ins, input logic ld, input logic [4:0] rd,
                        input logic br, input logic rs);
      @(posedge clk);
      #1;
      hz.id_instr   = ins;
      hz.ex_is_load = ld;
      hz.ex_rd      = rd;
      hz.br_taken   = br;
      reset         = rs;
      @(negedge clk);
   endtask

   function automatic logic [4:0] rreg();
      return ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [4:0] a = rreg();
      logic [4:0] b = rreg();
      logic [4:0] c = rreg();
      case ($urandom_range(0, 11))
         0:  return {11'b10101011000, a, 6'($urandom), b, c};
         1:  return {11'b11101011000, a, 6'($urandom), b, c};
         2:  return {11'b10011011000, a, 6'b011111, b, c};
         3:  return {11'b11111000000, 9'($urandom), 2'b00, a, b};
         4:  return {8'b10110100, 19'($urandom), a};
         5:  return {10'b1001000100, 12'($urandom), a, b};
         6:  return {11'b11111000010, 9'($urandom), 2'b00, a, b};
         7:  return {11'b11010011011, 5'd0, 6'($urandom), a, b};
         8:  return {11'b11010011010, 5'd0, 6'($urandom), a, b};
         9:  return {6'b000101, 26'($urandom)};
         10: return {8'h54, 19'($urandom), 5'b01011};
         default: return $urandom;
      endcase
   endfunction

   task automatic test_reset();
      apply(I_NOP, 1'b0, 5'd0, 1'b0, 1'b1);
      vectors++;
      if (obs !== P_RESET) begin miscompares++; $display("FAIL reset_c0 got %b want %b", obs, P_RESET); end
      apply(I_MUL, 1'b1, 5'd1, 1'b1, 1'b1);
      vectors++;
      if (obs !== P_RESET) begin miscompares++; $display("FAIL reset_c1 got %b want %b", obs, P_RESET); end
`ifdef HAZ_PERF_CNT_EN
      vectors++;
      if (stall_cnt !== 16'd0) begin miscompares++; $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); end
`endif
   endtask

   task automatic test_load_use();
      apply(I_ADDS, 1'b1, 5'd1, 1'b0, 1'b0);
      vectors++;
      if (obs !== P_STALL) begin miscompares++; $display("FAIL lu_rn got %b want %b", obs, P_STALL); end
      apply(I_ADDS, 1'b0, 5'd1, 1'b0, 1'b0);
      vectors++;
      if (obs !== P_DEF) begin miscompares++; $display("FAIL lu_release got %b want %b", obs, P_DEF); end
      apply(I_ADDS, 1'b1, 5'd2, 1'b0, 1'b0);
      vectors++;
      if (obs !== P_STALL) begin miscompares++; $display("FAIL lu_rm got %b want %b", obs, P_STALL); end
      apply(I_ADDS, 1'b1, 5'd4, 1'b0, 1'b0);
      vectors++;
      if (obs !== P_DEF) begin miscompares++; $display("FAIL lu_rd_not_source got %b want %b", obs, P_DEF); end
      apply(32'hF8000022, 1'b1, 5'd2, 1'b0, 1'b0);  // STUR X2,[X1]: Rt is a source
      vectors++;
      if (obs !== P_STALL) begin miscompares++; $display("FAIL lu_stur_rt got %b want %b", obs, P_STALL); end
      apply(32'h14000022, 1'b1, 5'd1, 1'b0, 1'b0);  // B: no sources even though [9:5]=1
      vectors++;
      if (obs !== P_DEF) begin miscompares++; $display("FAIL lu_b_nosrc got %b want %b", obs, P_DEF); end
   endtask

   task automatic test_no_false_stall();
      apply(I_ADDS, 1'b1, 5'd31, 1'b0, 1'b0);
      vectors++;
      if (obs !== P_DEF) begin miscompares++; $display("FAIL xzr_no_stall got %b want %b", obs, P_DEF); end
   endtask

   task automatic test_mul();
      apply(I_MUL, 1'b0, 5'd0, 1'b0, 1'b0);
      vectors++;
      if (obs !== P_MSTART) begin miscompares++; $display("FAIL mul_issue got %b want %b", obs, P_MSTART); end
      for (int i = 0; i < MUL_LAT - 1; i++) begin
         apply(I_NOP, 1'b0, 5'd0, 1'b0, 1'b0);
         vectors++;
         if (obs !== P_MBUSY) begin miscompares++; $display("FAIL mul_busy[%0d] got %b want %b", i, obs, P_MBUSY); end
      end
      apply(I_NOP, 1'b0, 5'd0, 1'b0, 1'b0);
      vectors++;
      if (obs !== P_DEF) begin miscompares++; $display("FAIL mul_done got %b want %b", obs, P_DEF); end
`ifdef HAZ_PERF_CNT_EN
      vectors++;
      if (stall_cnt !== exp_stall) begin miscompares++; $display("FAIL mul_stall_cnt got %0d want %0d", stall_cnt, exp_stall); end
`endif
   endtask

   task automatic test_branch();
      apply(I_NOP, 1'b0, 5'd0, 1'b1, 1'b0);
      vectors++;
      if (obs !== P_FLUSH0) begin miscompares++; $display("FAIL br_detect got %b want %b", obs, P_FLUSH0); end
      apply(I_ADDS, 1'b1, 5'd1, 1'b0, 1'b0);
      vectors++;
      if (obs !== P_FLUSH1) begin miscompares++; $display("FAIL br_flush_masks_lu got %b want %b", obs, P_FLUSH1); end
      apply(I_ADDS, 1'b1, 5'd1, 1'b0, 1'b0);
      vectors++;
      if (obs !== P_STALL) begin miscompares++; $display("FAIL br_then_lu got %b want %b", obs, P_STALL); end
      apply(I_NOP, 1'b0, 5'd0, 1'b0, 1'b0);
      vectors++;
      if (obs !== P_DEF) begin miscompares++; $display("FAIL br_done got %b want %b", obs, P_DEF); end
   endtask

   task automatic test_priority();
      apply(I_ADDS, 1'b1, 5'd1, 1'b1, 1'b0);
      vectors++;
      if (obs !== P_STALL) begin miscompares++; $display("FAIL prio_lu_over_br got %b want %b", obs, P_STALL); end
      apply(I_MUL, 1'b0, 5'd0, 1'b1, 1'b0);
      vectors++;
      if (obs !== P_MSTART) begin miscompares++; $display("FAIL prio_mul_over_br got %b want %b", obs, P_MSTART); end
      apply(I_NOP, 1'b0, 5'd0, 1'b1, 1'b0);
      vectors++;
      if (obs !== P_MBUSY) begin miscompares++; $display("FAIL prio_br_in_mul got %b want %b", obs, P_MBUSY); end
      for (int i = 0; i < MUL_LAT - 1; i++) apply(I_NOP, 1'b0, 5'd0, 1'b0, 1'b0);
      vectors++;
      if (obs !== P_DEF) begin miscompares++; $display("FAIL prio_recover got %b want %b", obs, P_DEF); end
   endtask

   task automatic test_back_to_back();
      for (int m = 0; m < 2; m++) begin
         apply(I_MUL, 1'b0, 5'd0, 1'b0, 1'b0);
         vectors++;
         if (obs !== P_MSTART) begin miscompares++; $display("FAIL b2b_issue[%0d] got %b want %b", m, obs, P_MSTART); end
         for (int i = 0; i < MUL_LAT - 1; i++) begin
            apply(I_MUL, 1'b0, 5'd0, 1'b0, 1'b0);
            vectors++;
            if (obs !== P_MBUSY) begin miscompares++; $display("FAIL b2b_busy[%0d][%0d] got %b want %b", m, i, obs, P_MBUSY); end
         end
      end
      apply(I_NOP, 1'b0, 5'd0, 1'b0, 1'b0);
      vectors++;
      if (obs !== P_DEF) begin miscompares++; $display("FAIL b2b_done got %b want %b", obs, P_DEF); end
   endtask

   task automatic test_reset_mid_seq();
      apply(I_MUL, 1'b0, 5'd0, 1'b0, 1'b0);
      apply(I_NOP, 1'b0, 5'd0, 1'b0, 1'b0);
      vectors++;
      if (obs !== P_MBUSY) begin miscompares++; $display("FAIL rmul_busy got %b want %b", obs, P_MBUSY); end
      apply(I_NOP, 1'b0, 5'd0, 1'b0, 1'b1);
      vectors++;
      if (obs !== P_RESET) begin miscompares++; $display("FAIL rmul_in_reset got %b want %b", obs, P_RESET); end
      apply(I_NOP, 1'b0, 5'd0, 1'b0, 1'b0);
      vectors++;
      if (obs !== P_DEF) begin miscompares++; $display("FAIL rmul_release got %b want %b", obs, P_DEF); end
      apply(I_NOP, 1'b0, 5'd0, 1'b1, 1'b0);
      apply(I_NOP, 1'b0, 5'd0, 1'b0, 1'b1);
      apply(I_NOP, 1'b0, 5'd0, 1'b0, 1'b0);
      vectors++;
      if (obs !== P_DEF) begin miscompares++; $display("FAIL rflush_release got %b want %b", obs, P_DEF); end
`ifdef HAZ_PERF_CNT_EN
      vectors++;
      if (stall_cnt !== 16'd0) begin miscompares++; $display("FAIL rflush_stall_cnt got %0d want 0", stall_cnt); end
`endif
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         apply(rand_instr(), 1'($urandom_range(0, 1)), rreg(),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 49) == 0));
         vectors++;
         if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL random[%0d] instr=%h got %b want %b", i, hz.id_instr, obs, exp_v);
         end
`ifdef HAZ_PERF_CNT_EN
         vectors++;
         if (stall_cnt !== exp_stall) begin
            miscompares++;
            $display("FAIL random_stall_cnt[%0d] got %0d want %0d", i, stall_cnt, exp_stall);
         end
`endif
      end
   endtask

   initial begin
      hz.id_instr   = I_NOP;
      hz.ex_is_load = 1'b0;
      hz.ex_rd      = 5'd0;
      hz.br_taken   = 1'b0;
      test_reset();
      test_load_use();
      test_no_false_stall();
      test_mul();
      test_branch();
      test_priority();
      test_back_to_back();
      test_reset_mid_seq();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
- Pipeline stall/flush sequencer for the 5-stage LEGv8 CPU.
- Sits beside the decode-stage control unit and drives the PC, IF/ID and ID/EX write enables.
- Handles three cases: load-use hazards that forwarding cannot cover, multi-cycle MUL occupancy of EX, and taken-branch flush of the fetch stage.
- Owns a small FSM plus a shared down-counter for MUL latency and flush length.

Parameters:
MUL_LAT, 4, total cycles the multiplier occupies EX (1..15); MUL_LAT-1 stall cycles follow issue
FLUSH_CYC, 1, cycles ifid_flush is asserted per taken branch, including the detect cycle (1..15)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high
id_instr  in  32  instruction currently in ID
ex_is_load  in  1  EX stage holds LDUR
ex_rd  in  5  destination register of the EX-stage instruction
br_taken  in  1  branch resolved taken in ID this cycle
pc_write  out  1  PC update enable
ifid_write  out  1  IF/ID register write enable
idex_bubble  out  1  load NOP controls into ID/EX
ifid_flush  out  1  clear IF/ID to NOP
mul_start  out  1  one-cycle pulse, MUL issuing to EX
mul_busy  out  1  multiplier occupied
state  out  2  FSM state: RUN=00, MUL=01, FLUSH=10

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset: while reset=1, the FSM is in RUN and cnt=0. Outputs while reset=1:
  - pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=1
  - mul_start=0, mul_busy=0, state=00
- Source decode from id_instr (Rn is always id_instr[9:5]):
  - ADDS, SUBS, MUL also use Rm = [20:16].
  - STUR, CBZ also use Rt = [4:0].
  - ADDI, LDUR, LSL, LSR use Rn only.
  - B and B.LT use no source.
- Opcode matches: ADDS [31:21]=10101011000; SUBS 11101011000; MUL 10011011000 with [15:10]=011111; STUR 11111000000; CBZ [31:24]=10110100.
- Load-use hazard (lu): ex_is_load=1 and ex_rd!=31 and ex_rd equals a used source.
- Outputs are combinational from state, cnt and inputs. Defaults: pc_write=1, ifid_write=1, idex_bubble=0, ifid_flush=0, mul_start=0, mul_busy=0.
- RUN, evaluated in priority order:
  1. lu: pc_write=0, ifid_write=0, idex_bubble=1; br_taken is ignored; stay in RUN.
  2. MUL in ID: mul_start=1 and MUL advances normally. If MUL_LAT>1, go to MUL with cnt=MUL_LAT-2.
  3. br_taken: ifid_flush=1. If FLUSH_CYC>1, go to FLUSH with cnt=FLUSH_CYC-2.
- MUL state:
  - pc_write=0, ifid_write=0, idex_bubble=1, mul_busy=1; br_taken is ignored.
  - If cnt==0, next state is RUN; otherwise cnt decrements.
  - The instruction held in ID is re-evaluated on return to RUN.
- FLUSH state:
  - ifid_flush=1, pc_write=1; lu and MUL detection are masked.
  - If cnt==0, next state is RUN; otherwise cnt decrements.
- Total stall per MUL is exactly MUL_LAT-1 cycles. Back-to-back MULs re-enter MUL with no gap cycle.
- A reset asserted mid-MUL or mid-FLUSH abandons the sequence. The next cycle after release is RUN with default outputs.
- Encoding 2'b11 is illegal and returns to RUN on the next edge.

Optional Feature:
HAZ_PERF_CNT_EN
- Defined: adds output stall_cnt[15:0], a saturating count of cycles with reset=0 and pc_write=0. It clears on reset and holds at 16'hFFFF.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Load-use: ex_is_load=1, ex_rd=1, id_instr=0xAB020024 (ADDS X4,X1,X2) -> that cycle pc_write=0, ifid_write=0, idex_bubble=1; next cycle with ex_is_load=0 -> defaults, state=00.
- No false stall: ex_is_load=1, ex_rd=31, same ADDS -> pc_write=1, idex_bubble=0.
- MUL with MUL_LAT=4: id_instr=0x9B027C23 (MUL X3,X1,X2) -> mul_start=1 for 1 cycle, then state=01 with mul_busy=1 and pc_write=0 for exactly 3 cycles, then state=00.
- Branch with FLUSH_CYC=2: br_taken=1 in RUN -> ifid_flush=1 for 2 consecutive cycles (state 00 then 10), then state=00.
- Priority: lu=1 and br_taken=1 together -> stall only, ifid_flush=0. br_taken=1 while in MUL -> ignored, mul_busy stays 1.
- Reset during MUL at cnt=1 -> next cycle after release: state=00, mul_busy=0, pc_write=1. With HAZ_PERF_CNT_EN: stall_cnt=0 after reset and increments once per stall cycle.
